// File: rtl/fj_pkg.sv
// -----------------------------------------------------------------------------
// fj_pkg
//   Shared types for the fork/join barrier: join-mode encoding, FSM state
//   encoding and the decoder that turns the raw 2-bit mode field into a
//   join mode.
//
// Optional feature macro used by the files that import this package:
//   FJ_LANE_TS_EN  -- per-lane completion timestamps (lane_ts output)
// -----------------------------------------------------------------------------
package fj_pkg;

    typedef enum logic [1:0] {
        FJ_ALL  = 2'b00,   // release when every lane has completed
        FJ_ANY  = 2'b01,   // release when at least one lane has completed
        FJ_NONE = 2'b10    // release immediately after the fork
    } fj_mode_e;

    typedef enum logic [2:0] {
        FJ_IDLE  = 3'd0,
        FJ_FORK  = 3'd1,
        FJ_WAIT  = 3'd2,
        FJ_JOIN  = 3'd3,
        FJ_DRAIN = 3'd4
    } fj_state_e;

    // The reserved encoding 2'b11 is treated as the safest mode, ALL.
    function automatic fj_mode_e fj_decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return FJ_ANY;
            2'b10:   return FJ_NONE;
            default: return FJ_ALL;
        endcase
    endfunction

endpackage : fj_pkg

// File: rtl/fj_lane_tracker.sv
// -----------------------------------------------------------------------------
// fj_lane_tracker
//   Per-lane bookkeeping for the fork/join barrier. A lane becomes pending on
//   the fork; its first done pulse afterwards clears pending and sets done.
//   Done pulses for a lane that is no longer pending are ignored.
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset
//   i_fork          in   fork cycle: arm the lane (pending=1, done=0)
//   i_track_en      in   done pulses are honoured only while this is high
//   i_lane_done     in   completion pulse from the worker lane
//   i_cnt           in   elapsed-cycle counter (FJ_LANE_TS_EN only)
//   o_ts            out  counter value captured at completion (FJ_LANE_TS_EN)
//   o_accept        out  this cycle's done pulse is accepted
//   o_pending_next  out  pending flag after this cycle's update
//   o_done_next     out  done flag after this cycle's update
//
// Configuration: FJ_LANE_TS_EN adds the CNT_W parameter, the timestamp
// register and the i_cnt / o_ts ports.
// -----------------------------------------------------------------------------
module fj_lane_tracker
    import fj_pkg::*;
`ifdef FJ_LANE_TS_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_fork,
    input  logic             i_track_en,
    input  logic             i_lane_done,
`ifdef FJ_LANE_TS_EN
    input  logic [CNT_W-1:0] i_cnt,
    output logic [CNT_W-1:0] o_ts,
`endif
    output logic             o_accept,
    output logic             o_pending_next,
    output logic             o_done_next
);

    logic r_pending;
    logic r_done;

    assign o_accept       = i_track_en & i_lane_done & r_pending;
    assign o_pending_next = r_pending & ~o_accept;
    assign o_done_next    = r_done | o_accept;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the clock edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_done    <= 1'b0;
        end else if (i_fork) begin
            r_pending <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_pending <= o_pending_next;
            r_done    <= o_done_next;
        end
    end

`ifdef FJ_LANE_TS_EN
    logic [CNT_W-1:0] r_ts;

    // Cleared on the fork so a lane that never completes reads zero.
    always_ff @(posedge clk) begin
        if (rst || i_fork) begin
            r_ts <= '0;
        end else if (o_accept) begin
            r_ts <= i_cnt;
        end
    end

    assign o_ts = r_ts;
`endif

endmodule : fj_lane_tracker

// File: rtl/fork_join_barrier.sv
// -----------------------------------------------------------------------------
// fork_join_barrier
//   Accepts one job from the dispatcher, fires a one-cycle start to all
//   N_LANES worker lanes, collects their done pulses and presents a join
//   result to downstream according to the job's join mode (ALL/ANY/NONE).
//   A new job is only accepted once every lane of the current job has
//   completed, whatever the mode.
//
// Parameters
//   N_LANES  number of worker lanes (2..16)
//   CNT_W    width of the elapsed-cycle counter; saturates at all-ones
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start_valid  in   upstream job request
//   start_ready  out  high only in IDLE
//   mode_i       in   join mode, sampled on the start handshake
//                     (00 ALL, 01 ANY, 10 NONE, 11 treated as ALL)
//   lane_start   out  one-cycle fork pulse to every lane
//   lane_done    in   one-cycle completion pulse per lane
//   join_valid   out  join result available, held until join_ready
//   join_ready   in   downstream accepts the join result
//   done_mask    out  lanes complete when the join condition was met
//   first_lane   out  earliest-completing lane (ties -> lowest; 0 for NONE)
//   join_cycles  out  cycles from the fork to the join condition
//   busy         out  high in every state except IDLE
//   lane_ts      out  per-lane completion timestamps (FJ_LANE_TS_EN only)
//
// Configuration: define FJ_LANE_TS_EN to add lane_ts.
// -----------------------------------------------------------------------------
module fork_join_barrier
    import fj_pkg::*;
#(
    parameter int N_LANES = 2,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [1:0]                 mode_i,
    output logic [N_LANES-1:0]         lane_start,
    input  logic [N_LANES-1:0]         lane_done,
    output logic                       join_valid,
    input  logic                       join_ready,
    output logic [N_LANES-1:0]         done_mask,
    output logic [$clog2(N_LANES)-1:0] first_lane,
    output logic [CNT_W-1:0]           join_cycles,
`ifdef FJ_LANE_TS_EN
    output logic [N_LANES-1:0][CNT_W-1:0] lane_ts,
`endif
    output logic                       busy
);

    localparam int LW = $clog2(N_LANES);

    fj_state_e          r_state;
    fj_state_e          w_state_next;
    fj_mode_e           r_mode;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;

    logic               w_start_hs;
    logic               w_fork;
    logic               w_track_en;
    logic               w_cond;
    logic               w_snap;

    logic [N_LANES-1:0] w_accept;
    logic [N_LANES-1:0] w_pending_next;
    logic [N_LANES-1:0] w_done_next;

    logic               r_have_first;
    logic [LW-1:0]      r_first;
    logic [LW-1:0]      w_accept_enc;
    logic [LW-1:0]      w_first_next;

    logic [N_LANES-1:0] r_done_mask;
    logic [LW-1:0]      r_first_lane;
    logic [CNT_W-1:0]   r_join_cycles;

    // ------------------------------------------------------------------
    // Lane trackers
    // ------------------------------------------------------------------
    assign w_fork     = (r_state == FJ_FORK);
    // Lanes keep being tracked after the join so DRAIN knows when the
    // last straggler has finished.
    assign w_track_en = (r_state == FJ_WAIT) || (r_state == FJ_JOIN) ||
                        (r_state == FJ_DRAIN);

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        fj_lane_tracker
`ifdef FJ_LANE_TS_EN
        #(
            .CNT_W          (CNT_W)
        )
`endif
        u_tracker (
            .clk            (clk),
            .rst            (rst),
            .i_fork         (w_fork),
            .i_track_en     (w_track_en),
            .i_lane_done    (lane_done[g]),
`ifdef FJ_LANE_TS_EN
            .i_cnt          (r_cnt),
            .o_ts           (lane_ts[g]),
`endif
            .o_accept       (w_accept[g]),
            .o_pending_next (w_pending_next[g]),
            .o_done_next    (w_done_next[g])
        );
    end

    // ------------------------------------------------------------------
    // First-completion tracking: lowest index among this cycle's accepted
    // done pulses, latched the first time any lane completes.
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_accept_enc = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (w_accept[i]) begin
                w_accept_enc = LW'(i);
            end
        end
    end

    assign w_first_next = r_have_first ? r_first : w_accept_enc;

    always_ff @(posedge clk) begin
        if (rst || w_fork) begin
            r_have_first <= 1'b0;
            r_first      <= '0;
        end else if (!r_have_first && (|w_accept)) begin
            r_have_first <= 1'b1;
            r_first      <= w_accept_enc;
        end
    end

    // ------------------------------------------------------------------
    // Join condition, evaluated on the masks after this cycle's update
    // ------------------------------------------------------------------
    always_comb begin
        w_cond = 1'b0;
        case (r_mode)
            FJ_ANY:  w_cond = |w_done_next;
            FJ_NONE: w_cond = 1'b1;
            default: w_cond = ~|w_pending_next;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign w_start_hs = start_valid && (r_state == FJ_IDLE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FJ_IDLE: begin
                if (w_start_hs) w_state_next = FJ_FORK;
            end
            FJ_FORK: begin
                w_state_next = (r_mode == FJ_NONE) ? FJ_JOIN : FJ_WAIT;
            end
            FJ_WAIT: begin
                if (w_cond) w_state_next = FJ_JOIN;
            end
            FJ_JOIN: begin
                // A done arriving in the handshake cycle is already folded
                // into w_pending_next, so it can skip DRAIN entirely.
                if (join_ready) begin
                    w_state_next = (|w_pending_next) ? FJ_DRAIN : FJ_IDLE;
                end
            end
            FJ_DRAIN: begin
                if (~|w_pending_next) w_state_next = FJ_IDLE;
            end
            default: w_state_next = FJ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FJ_IDLE;
            r_mode  <= FJ_ALL;
        end else begin
            r_state <= w_state_next;
            if (w_start_hs) begin
                r_mode <= fj_decode_mode(mode_i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Elapsed-cycle counter: 0 in the FORK cycle, k in the k-th cycle after
    // it. It keeps running through JOIN and DRAIN so late-lane timestamps
    // stay meaningful; join_cycles is snapshotted and unaffected.
    // ------------------------------------------------------------------
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst || w_start_hs) begin
            r_cnt <= '0;
        end else if (r_state != FJ_IDLE) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // ------------------------------------------------------------------
    // Output snapshot, taken on the transition into JOIN and then frozen
    // ------------------------------------------------------------------
    assign w_snap = (w_fork && (r_mode == FJ_NONE)) ||
                    ((r_state == FJ_WAIT) && w_cond);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_mask   <= '0;
            r_first_lane  <= '0;
            r_join_cycles <= '0;
        end else if (w_snap) begin
            if (w_fork) begin
                // NONE: the trackers still hold the previous job's flags
                // during FORK, so report an empty result explicitly.
                r_done_mask   <= '0;
                r_first_lane  <= '0;
                r_join_cycles <= '0;
            end else begin
                r_done_mask   <= w_done_next;
                r_first_lane  <= w_first_next;
                r_join_cycles <= r_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign start_ready = (r_state == FJ_IDLE);
    assign busy        = (r_state != FJ_IDLE);
    assign join_valid  = (r_state == FJ_JOIN);
    assign lane_start  = {N_LANES{w_fork}};
    assign done_mask   = r_done_mask;
    assign first_lane  = r_first_lane;
    assign join_cycles = r_join_cycles;

endmodule : fork_join_barrier

// File: tb/tb_fork_join_barrier.sv
// -----------------------------------------------------------------------------
// tb_fork_join_barrier
//   Directed bench for fork_join_barrier with N_LANES=2. Two instances share
//   all stimulus: one with CNT_W=16 and one with CNT_W=4 to exercise counter
//   saturation. Cycle offsets are counted from the FORK cycle (rel=0).
// -----------------------------------------------------------------------------
module tb_fork_join_barrier;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic [1:0]  mode_i;
    logic [1:0]  lane_done;
    logic        join_ready;

    logic        start_ready, join_valid, busy;
    logic [1:0]  lane_start, done_mask;
    logic        first_lane;
    logic [15:0] join_cycles;

    logic        sr4, jv4, busy4;
    logic [1:0]  ls4, dm4;
    logic        fl4;
    logic [3:0]  jc4;

`ifdef FJ_LANE_TS_EN
    logic [N-1:0][15:0] lane_ts;
    logic [N-1:0][3:0]  lane_ts4;
`endif

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int rel     = 0;

    always #5 clk = ~clk;

    fork_join_barrier #(.N_LANES(N), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .mode_i      (mode_i),
        .lane_start  (lane_start),
        .lane_done   (lane_done),
        .join_valid  (join_valid),
        .join_ready  (join_ready),
        .done_mask   (done_mask),
        .first_lane  (first_lane),
        .join_cycles (join_cycles),
`ifdef FJ_LANE_TS_EN
        .lane_ts     (lane_ts),
`endif
        .busy        (busy)
    );

    fork_join_barrier #(.N_LANES(N), .CNT_W(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (sr4),
        .mode_i      (mode_i),
        .lane_start  (ls4),
        .lane_done   (lane_done),
        .join_valid  (jv4),
        .join_ready  (join_ready),
        .done_mask   (dm4),
        .first_lane  (fl4),
        .join_cycles (jc4),
`ifdef FJ_LANE_TS_EN
        .lane_ts     (lane_ts4),
`endif
        .busy        (busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 unit after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic run_to(input int target);
        while (rel < target) tick();
    endtask

    // Handshake in the current (IDLE) cycle; returns in the FORK cycle.
    task automatic start_job(input logic [1:0] m);
        start_valid = 1'b1;
        mode_i      = m;
        tick();
        start_valid = 1'b0;
        mode_i      = 2'b00;
        rel         = 0;
    endtask

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        mode_i      = 2'b00;
        lane_done   = 2'b00;
        join_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ---- reset state ----
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_lane_start",  32'(lane_start),  32'd0);
        check("rst_join_valid",  32'(join_valid),  32'd0);
        check("rst_done_mask",   32'(done_mask),   32'd0);
        check("rst_first_lane",  32'(first_lane),  32'd0);
        check("rst_join_cycles", 32'(join_cycles), 32'd0);
        check("rst_jc4",         32'(jc4),         32'd0);

        // ---- lane_done in IDLE is ignored ----
        lane_done = 2'b11;
        tick();
        lane_done = 2'b00;
        tick();
        check("idle_done_busy",  32'(busy),        32'd0);
        check("idle_done_ready", 32'(start_ready), 32'd1);

        // ---- ALL: lane0 at +20, lane1 at +30 ----
        start_job(2'b00);
        check("all_fork_start", 32'(lane_start),  32'd3);
        check("all_fork_busy",  32'(busy),        32'd1);
        check("all_fork_ready", 32'(start_ready), 32'd0);
        tick();
        check("all_start_pulse", 32'(lane_start), 32'd0);
        run_to(20);
        lane_done = 2'b01;
        tick();
        lane_done = 2'b00;
        run_to(25);
        lane_done = 2'b01;            // duplicate, lane0 no longer pending
        tick();
        lane_done = 2'b00;
        run_to(30);
        check("all_jv_early", 32'(join_valid), 32'd0);
        lane_done = 2'b10;
        tick();
        lane_done = 2'b00;
        check("all_jv",     32'(join_valid),  32'd1);
        check("all_mask",   32'(done_mask),   32'd3);
        check("all_first",  32'(first_lane),  32'd0);
        check("all_cycles", 32'(join_cycles), 32'd30);
        check("all_jc4_sat", 32'(jc4),        32'd15);
`ifdef FJ_LANE_TS_EN
        check("all_ts0", 32'(lane_ts[0]), 32'd20);
        check("all_ts1", 32'(lane_ts[1]), 32'd30);
`endif
        join_ready = 1'b1;
        tick();
        join_ready = 1'b0;
        check("all_idle_ready", 32'(start_ready), 32'd1);
        check("all_idle_busy",  32'(busy),        32'd0);
        check("all_idle_jv",    32'(join_valid),  32'd0);

        // ---- ANY: done during FORK ignored, lane0 +20, lane1 +30 ----
        start_job(2'b01);
        lane_done = 2'b10;
        tick();
        lane_done = 2'b00;
        run_to(20);
        check("any_jv_early", 32'(join_valid), 32'd0);
        lane_done = 2'b01;
        tick();
        lane_done = 2'b00;
        check("any_jv",     32'(join_valid),  32'd1);
        check("any_mask",   32'(done_mask),   32'd1);
        check("any_first",  32'(first_lane),  32'd0);
        check("any_cycles", 32'(join_cycles), 32'd20);
        join_ready = 1'b1;
        tick();
        join_ready = 1'b0;
        check("any_drain_jv",    32'(join_valid),  32'd0);
        check("any_drain_busy",  32'(busy),        32'd1);
        check("any_drain_ready", 32'(start_ready), 32'd0);
        run_to(30);
        check("any_drain_ready30", 32'(start_ready), 32'd0);
        lane_done = 2'b10;
        tick();
        lane_done = 2'b00;
        check("any_idle_ready", 32'(start_ready), 32'd1);
        check("any_idle_busy",  32'(busy),        32'd0);

        // ---- NONE ----
        start_job(2'b10);
        check("none_fork_start", 32'(lane_start), 32'd3);
        tick();
        check("none_jv",     32'(join_valid),  32'd1);
        check("none_mask",   32'(done_mask),   32'd0);
        check("none_cycles", 32'(join_cycles), 32'd0);
        check("none_first",  32'(first_lane),  32'd0);
        join_ready = 1'b1;
        tick();
        join_ready = 1'b0;
        check("none_drain_jv",    32'(join_valid),  32'd0);
        check("none_drain_busy",  32'(busy),        32'd1);
        check("none_drain_ready", 32'(start_ready), 32'd0);
        tick();
        check("none_drain_ready3", 32'(start_ready), 32'd0);
        lane_done = 2'b11;
        tick();
        lane_done = 2'b00;
        check("none_idle_ready", 32'(start_ready), 32'd1);
        check("none_idle_busy",  32'(busy),        32'd0);

        // ---- mode 11 behaves as ALL; lane1 completes first ----
        start_job(2'b11);
        run_to(5);
        lane_done = 2'b10;
        tick();
        lane_done = 2'b00;
        run_to(8);
        check("m11_jv_early", 32'(join_valid), 32'd0);
        lane_done = 2'b01;
        tick();
        lane_done = 2'b00;
        check("m11_jv",     32'(join_valid),  32'd1);
        check("m11_mask",   32'(done_mask),   32'd3);
        check("m11_first",  32'(first_lane),  32'd1);
        check("m11_cycles", 32'(join_cycles), 32'd8);
        check("m11_jc4",    32'(jc4),         32'd8);
        join_ready = 1'b1;
        tick();
        join_ready = 1'b0;
        check("m11_idle_ready", 32'(start_ready), 32'd1);

        // ---- ANY, both lanes same cycle, join_ready held low 5 cycles ----
        start_job(2'b01);
        run_to(6);
        lane_done = 2'b11;
        tick();
        lane_done = 2'b00;
        for (int i = 0; i < 5; i++) begin
            check("sim_hold_jv",     32'(join_valid),  32'd1);
            check("sim_hold_mask",   32'(done_mask),   32'd3);
            check("sim_hold_first",  32'(first_lane),  32'd0);
            check("sim_hold_cycles", 32'(join_cycles), 32'd6);
            tick();
        end
        check("sim_jv_still", 32'(join_valid), 32'd1);
        join_ready = 1'b1;
        tick();
        join_ready = 1'b0;
        check("sim_idle_ready", 32'(start_ready), 32'd1);

        // ---- ANY, remaining lane finishes in the handshake cycle ----
        start_job(2'b01);
        run_to(3);
        lane_done = 2'b01;
        tick();
        lane_done = 2'b00;
        check("hs_jv",     32'(join_valid), 32'd1);
        check("hs_mask",   32'(done_mask),  32'd1);
        join_ready = 1'b1;
        lane_done  = 2'b10;
        tick();
        join_ready = 1'b0;
        lane_done  = 2'b00;
        check("hs_idle_ready", 32'(start_ready), 32'd1);
        check("hs_idle_busy",  32'(busy),        32'd0);

        // ---- reset asserted in WAIT, then a clean job ----
        start_job(2'b00);
        run_to(5);
        lane_done = 2'b01;
        tick();
        lane_done = 2'b00;
        run_to(8);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_ready",  32'(start_ready), 32'd1);
        check("mrst_busy",   32'(busy),        32'd0);
        check("mrst_jv",     32'(join_valid),  32'd0);
        check("mrst_start",  32'(lane_start),  32'd0);
        check("mrst_mask",   32'(done_mask),   32'd0);
        check("mrst_first",  32'(first_lane),  32'd0);
        check("mrst_cycles", 32'(join_cycles), 32'd0);
        tick();
        check("mrst_start2", 32'(lane_start), 32'd0);

        start_job(2'b00);
        check("new_fork_start", 32'(lane_start), 32'd3);
        run_to(3);
        lane_done = 2'b01;
        tick();
        lane_done = 2'b10;
        tick();
        lane_done = 2'b00;
        check("new_jv",     32'(join_valid),  32'd1);
        check("new_mask",   32'(done_mask),   32'd3);
        check("new_first",  32'(first_lane),  32'd0);
        check("new_cycles", 32'(join_cycles), 32'd4);
        join_ready = 1'b1;
        tick();
        join_ready = 1'b0;
        check("new_idle_ready", 32'(start_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fork_join_barrier
